// File: rtl/hash_mem_pkg.sv
// Purpose: shared constants and types for the hashing-core word memory responder.
//   ADDR_W / DATA_W  : address and word widths used on both the core and host ports
//   DEF_*            : default geometry of the word array and the result window
//   host_state_e     : host side-port access FSM states
package hash_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam int                DEF_DEPTH    = 256;
  localparam logic [ADDR_W-1:0] DEF_OUT_BASE = 16'h00A0;
  localparam int                DEF_NUM_OUT  = 16;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } host_state_e;

endpackage

// File: rtl/hash_mem_array.sv
// Purpose: single-write-port word RAM with synchronous write.
//   The read word for the current index is presented combinationally; the
//   owner captures it into its own output registers on the same edge as any
//   write, which gives read-first behaviour (the old word is captured).
// Ports:
//   clk      in  clock
//   i_we     in  write enable (already qualified by the owner)
//   i_idx    in  word index
//   i_wdata  in  write data
//   o_rdata  out word currently stored at i_idx
module hash_mem_array
  import hash_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately not reset so that words survive a reset pulse.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/hash_mem_responder.sv
// Purpose: memory-side responder for the hashing core. Serves core reads and
//   writes from a DEPTH x 32 word array with a fixed one-cycle read latency,
//   gives a host side-port access while the core is idle, counts result-window
//   writes and flags out-of-range accesses.
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   core_busy           core running; selects the core port and blocks the host
//   mem_addr/mem_we/mem_write_data  core access, sampled every busy edge
//   mem_read_data       registered core read data (holds while core idle)
//   host_req/host_we/host_addr/host_wdata  host access request
//   host_ack            one-cycle completion pulse
//   host_rdata          host read data, valid with host_ack
//   results_ready       every result-window word written in the current run
//   err_oob             sticky out-of-range access flag
//   dbg_host_state      current host FSM state
//
// Host handshake: host raises host_req with host_we/host_addr/host_wdata stable
// and keeps it high until it sees host_ack. The access itself happens on the
// first edge where the FSM is idle, host_req is high and core_busy is low; the
// following cycle is the ack cycle, in which the host must drop host_req.
// A request still high in the idle state after the ack is a new request.
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] OUT_BASE = DEF_OUT_BASE,
  parameter int                NUM_OUT  = DEF_NUM_OUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_busy,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              results_ready,
  output logic              err_oob,
  output host_state_e       dbg_host_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(NUM_OUT + 1);

  // Address compares are done one bit wider so DEPTH and the window end can
  // equal 2**ADDR_W without wrapping.
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WIN_LO_X  = {1'b0, OUT_BASE};
  localparam logic [ADDR_W:0] WIN_HI_X  = {1'b0, OUT_BASE} + (ADDR_W+1)'(NUM_OUT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_OUT);

  host_state_e       r_state;
  host_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_mem_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_err;
  logic              r_busy_d;
  logic [CNT_W-1:0]  r_wr_count;

  logic              w_host_fire;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_range;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_rdata_safe;
  logic              w_busy_rise;
  logic              w_res_wr;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Host and core never share an edge: the host only fires while core_busy=0.
  assign w_host_fire = (r_state == H_IDLE) & host_req & ~core_busy;

  assign w_addr     = core_busy ? mem_addr : host_addr;
  assign w_wdata    = core_busy ? mem_write_data : host_wdata;
  assign w_in_range = {1'b0, w_addr} < DEPTH_X;

  // reset_n gates the write so nothing lands in the array while in reset.
  assign w_we = reset_n & w_in_range &
                (core_busy ? mem_we : (w_host_fire & host_we));

  hash_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_addr[IDX_W-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_rdata_safe = w_in_range ? w_rdata : '0;

  // Host FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      H_IDLE:  if (w_host_fire) w_state_nxt = H_ACK;
      H_ACK:   w_state_nxt = H_IDLE;
      default: w_state_nxt = H_IDLE;
    endcase
  end

  // Result-window counter. A new run (core_busy rising) restarts the count;
  // a window write on that same first edge is counted into the new run.
  assign w_busy_rise = core_busy & ~r_busy_d;
  assign w_res_wr    = core_busy & mem_we &
                       ({1'b0, mem_addr} >= WIN_LO_X) &
                       ({1'b0, mem_addr} <  WIN_HI_X);

  always_comb begin
    w_cnt_base = w_busy_rise ? '0 : r_wr_count;
    w_cnt_nxt  = w_cnt_base;
    if (w_res_wr && (w_cnt_base != CNT_FULL)) w_cnt_nxt = w_cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= H_IDLE;
      r_mem_rdata  <= '0;
      r_host_rdata <= '0;
      r_err        <= 1'b0;
      r_busy_d     <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_d   <= core_busy;
      r_wr_count <= w_cnt_nxt;
      if (core_busy)   r_mem_rdata  <= w_rdata_safe;
      if (w_host_fire) r_host_rdata <= w_rdata_safe;
      if ((core_busy | w_host_fire) & ~w_in_range) r_err <= 1'b1;
    end
  end

  assign mem_read_data  = r_mem_rdata;
  assign host_rdata     = r_host_rdata;
  assign host_ack       = (r_state == H_ACK);
  assign results_ready  = (r_wr_count == CNT_FULL);
  assign err_oob        = r_err;
  assign dbg_host_state = r_state;

endmodule

// File: tb/tb_hash_mem_responder.sv
module tb_hash_mem_responder;
  import hash_mem_pkg::*;

  localparam int DEPTH    = 256;
  localparam int OUT_BASE = 160;
  localparam int NUM_OUT  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        core_busy = 1'b0;
  logic [15:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        results_ready;
  logic        err_oob;
  host_state_e dbg_host_state;

  always #5 clk = ~clk;

  hash_mem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .core_busy      (core_busy),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ack       (host_ack),
    .host_rdata     (host_rdata),
    .results_ready  (results_ready),
    .err_oob        (err_oob),
    .dbg_host_state (dbg_host_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] exp_mrd, exp_hrd;
  bit          mrd_known, hrd_known, exp_ack, exp_err, prev_busy;
  int          cnt;

  task automatic m_reset();
    exp_mrd = '0; mrd_known = 1; exp_hrd = '0; hrd_known = 1;
    exp_ack = 0; exp_err = 0; prev_busy = 0; cnt = 0;
  endtask

  function automatic bit lookup(input int a, output logic [31:0] d);
    if (a >= DEPTH) begin d = '0; return 1; end
    if (m_mem.exists(a)) begin d = m_mem[a]; return 1; end
    d = 'x;
    return 0;
  endfunction

  task automatic m_step();
    bit          rise, k;
    logic [31:0] d;
    int          ha, ca;
    ha = int'(host_addr);
    ca = int'(mem_addr);
    rise = core_busy && !prev_busy;
    prev_busy = core_busy;
    if (exp_ack) exp_ack = 0;
    else if (host_req && !core_busy) begin
      k = lookup(ha, d);
      exp_hrd = d; hrd_known = k;
      if (ha >= DEPTH) exp_err = 1;
      else if (host_we) m_mem[ha] = host_wdata;
      exp_ack = 1;
    end
    if (rise) cnt = 0;
    if (core_busy) begin
      k = lookup(ca, d);
      exp_mrd = d; mrd_known = k;
      if (ca >= DEPTH) exp_err = 1;
      else if (mem_we) begin
        m_mem[ca] = mem_write_data;
        if (ca >= OUT_BASE && ca < OUT_BASE + NUM_OUT && cnt < NUM_OUT) cnt++;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  initial forever begin
    @(negedge clk);
    chk("host_ack", host_ack, exp_ack);
    chk("results_ready", results_ready, cnt == NUM_OUT);
    chk("err_oob", err_oob, exp_err);
    if (mrd_known) chk("mem_read_data", mem_read_data, exp_mrd);
    if (hrd_known) chk("host_rdata", host_rdata, exp_hrd);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic host_access(input bit we, input int addr, input logic [31:0] wd,
                             output logic [31:0] rd);
    int n;
    n = 0;
    host_req = 1; host_we = we; host_addr = 16'(addr); host_wdata = wd;
    do begin tick(); n++; end while (!host_ack && n < 40);
    chk("host_ack_seen", host_ack, 1);
    rd = host_rdata;
    host_req = 0;
    tick();
    chk("host_ack_one_cycle", host_ack, 0);
  endtask

  task automatic core_cycle(input bit we, input int addr, input logic [31:0] wd);
    core_busy = 1; mem_we = we; mem_addr = 16'(addr); mem_write_data = wd;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int n, n_ack, r;

    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read_data", mem_read_data, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_results_ready", results_ready, 0);
    chk("rst_err_oob", err_oob, 0);
    @(posedge clk); #2 reset_n = 1;
    tick();

    // host preload, then back-to-back core reads
    for (int k = 0; k < 4; k++) host_access(1, k, 32'h11111111 + k, rd);
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin core_busy = 1; mem_we = 0; mem_addr = 16'(k); end
      else core_busy = 0;
      if (k > 0) begin
        @(negedge clk);
        chk("core_read_seq", mem_read_data, 32'h11111111 + k - 1);
      end
      @(posedge clk); #2;
    end

    // fill the result window
    for (int k = 0; k < NUM_OUT; k++) begin
      core_cycle(1, OUT_BASE + k, 32'hDEADBEEF);
      if (k == NUM_OUT - 2) chk("rr_before_last", results_ready, 0);
    end
    core_busy = 0; mem_we = 0;
    chk("rr_after_last", results_ready, 1);
    host_access(0, OUT_BASE + 5, 32'h0, rd);
    chk("host_read_result", rd, 32'hDEADBEEF);

    // host read stalled behind a busy core
    core_busy = 1; mem_we = 0; mem_addr = 16'd0;
    host_req = 1; host_we = 0; host_addr = 16'(OUT_BASE + 5);
    n_ack = 0;
    repeat (10) begin tick(); if (host_ack) n_ack++; end
    chk("stall_no_ack", n_ack, 0);
    core_busy = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_ack && n < 10);
    chk("stall_ack_latency", n, 2);
    chk("stall_rdata", host_rdata, 32'hDEADBEEF);
    host_req = 0;
    tick();

    // read-first core write
    host_access(1, 7, 32'h12345678, rd);
    core_cycle(1, 7, 32'hA5A5A5A5);
    chk("read_first_old", mem_read_data, 32'h12345678);
    core_cycle(0, 7, 32'h0);
    chk("read_after_write", mem_read_data, 32'hA5A5A5A5);
    core_busy = 0; mem_we = 0;
    tick();

    // out-of-range host accesses
    chk("err_before_oob", err_oob, 0);
    host_access(1, 300, 32'h55555555, rd);
    chk("err_after_oob_wr", err_oob, 1);
    host_access(0, 300, 32'h0, rd);
    chk("oob_read_zero", rd, 32'h0);
    repeat (5) tick();
    chk("err_sticky", err_oob, 1);

    // randomized traffic on both ports
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(31) == 0) core_busy = ~core_busy;
      mem_we = 1'($urandom_range(1));
      r = $urandom_range(99);
      if (r < 60)      mem_addr = 16'(OUT_BASE + $urandom_range(NUM_OUT - 1));
      else if (r < 97) mem_addr = 16'($urandom_range(DEPTH - 1));
      else             mem_addr = 16'($urandom_range(65535, DEPTH));
      mem_write_data = $urandom;
      if (host_req && host_ack) host_req = 0;
      else if (!host_req && !host_ack && $urandom_range(3) == 0) begin
        host_req   = 1;
        host_we    = 1'($urandom_range(1));
        host_addr  = ($urandom_range(49) == 0) ? 16'($urandom_range(65535, DEPTH))
                                               : 16'($urandom_range(DEPTH - 1));
        host_wdata = $urandom;
      end
      tick();
    end

    // reset during the ack cycle
    core_busy = 0; mem_we = 0; host_req = 0;
    tick(); tick();
    host_req = 1; host_we = 1; host_addr = 16'd9; host_wdata = 32'hCAFEF00D;
    n = 0;
    do begin tick(); n++; end while (!host_ack && n < 10);
    chk("ack_before_reset", host_ack, 1);
    reset_n = 0; host_req = 0;
    #1;
    chk("ack_dropped_by_reset", host_ack, 0);
    chk("err_cleared_by_reset", err_oob, 0);
    @(posedge clk); #2 reset_n = 1;
    tick();
    host_access(0, 9, 32'h0, rd);
    chk("write_kept_over_reset", rd, 32'hCAFEF00D);

    // new run clears results_ready
    for (int k = 0; k < NUM_OUT; k++) core_cycle(1, OUT_BASE + k, 32'(k));
    core_busy = 0; mem_we = 0;
    tick();
    chk("rr_full_again", results_ready, 1);
    core_busy = 1;
    tick();
    chk("rr_cleared_on_rise", results_ready, 0);
    core_busy = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
